// File: rtl/decode_regread_stage.sv
// decode_regread_stage: RV32I OP/OP-IMM decode, register read and busy scoreboard ahead of the ALU.
// Owns the register file write port driven by writeback.
module decode_regread_stage #(
    parameter bit ENABLE_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2,
    output logic [11:0] out_imm,
    output logic        out_imm_select,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [4:0]  out_rd,
    output logic        out_illegal,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);
    logic [31:0] rf_q [32];
    logic [31:0] busy_q, busy_d, busy_eff;
    logic        valid_q, valid_d, ill_q, ill_d, imm_sel_q, imm_sel_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [11:0] imm_q, imm_d;
    logic [2:0]  f3_q, f3_d;
    logic [6:0]  f7_q, f7_d;
    logic [4:0]  rd_q, rd_d;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic        is_op, is_imm, legal, hazard, accept, wb_hit;
    logic [31:0] rs1_val, rs2_val;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign is_op  = opcode == 7'h33;
    assign is_imm = opcode == 7'h13;
    assign legal  = is_op || is_imm;
    assign wb_hit = wb_en && wb_rd != 5'd0;

    // A register being written back this cycle is already free when bypassing.
    always_comb begin
        busy_eff = '0;
        for (int i = 0; i < 32; i++)
            busy_eff[i] = busy_q[i] && !(ENABLE_BYPASS && wb_en && wb_rd == 5'(i));
    end

    assign hazard   = legal && (busy_eff[rs1] || busy_eff[rd] || (is_op && busy_eff[rs2]));
    assign in_ready = rst_n && (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    assign rs1_val = rs1 == 5'd0 ? 32'd0 :
                     (ENABLE_BYPASS && wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
    assign rs2_val = rs2 == 5'd0 ? 32'd0 :
                     (ENABLE_BYPASS && wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];

    always_comb begin
        valid_d   = accept ? 1'b1 : (valid_q && !out_ready);
        ill_d     = accept ? !legal : ill_q;
        imm_sel_d = accept ? is_imm : imm_sel_q;
        rs1_d     = accept ? (legal ? rs1_val : 32'd0) : rs1_q;
        rs2_d     = accept ? (is_op ? rs2_val : 32'd0) : rs2_q;
        imm_d     = accept ? (is_imm ? in_instr[31:20] : 12'd0) : imm_q;
        f3_d      = accept ? in_instr[14:12] : f3_q;
        f7_d      = accept ? in_instr[31:25] : f7_q;
        rd_d      = accept ? (legal ? rd : 5'd0) : rd_q;
        busy_d    = busy_q;
        if (wb_hit)
            busy_d[wb_rd] = 1'b0;
        if (accept && legal && rd != 5'd0)
            busy_d[rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ill_q     <= 1'b0;
            imm_sel_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            rd_q      <= '0;
            busy_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            ill_q     <= ill_d;
            imm_sel_q <= imm_sel_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else if (wb_hit) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign out_valid      = valid_q;
    assign out_illegal    = ill_q;
    assign out_imm_select = imm_sel_q;
    assign out_rs1        = rs1_q;
    assign out_rs2        = rs2_q;
    assign out_imm        = imm_q;
    assign out_funct3     = f3_q;
    assign out_funct7     = f7_q;
    assign out_rd         = rd_q;
endmodule

// File: doc/decode_regread_stage.md
Name: decode_regread_stage

Overview:
- Pipeline stage directly upstream of the integer ALU.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes OP (0x33) and OP-IMM (0x13).
- Reads a 32x32 register file and presents registered operands and control fields to the ALU, plus the destination register for writeback.
- Owns the register file write port, driven from writeback, and a per-register busy scoreboard that stalls RAW and WAW hazards.

Parameters:
- ENABLE_BYPASS, 1: when 1, writeback data in the same cycle is forwarded to register reads and clears the busy check; when 0, a hazard stalls until the cycle after writeback.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_instr  in  32  raw instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- out_rs1  out  32  rs1 register value.
- out_rs2  out  32  rs2 register value (0 for OP-IMM).
- out_imm  out  12  instr[31:20] for OP-IMM, else 0.
- out_imm_select  out  1  1 for OP-IMM.
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rd  out  5  destination register (0 if illegal).
- out_illegal  out  1  opcode is neither 0x33 nor 0x13.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback register.
- wb_data  in  32  writeback value.

Behaviour:
- Reset (async, rst_n=0):
  - All register file entries = 0; all busy bits = 0.
  - out_valid = 0; every out_* data output = 0; in_ready = 0 while rst_n = 0.
- Decode fields: opcode = instr[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25].
- Hazard:
  - Legal instruction: hazard if busy[rs1], busy[rd], or (OP only) busy[rs2] is set for a nonzero register index.
  - With ENABLE_BYPASS=1, a busy bit being cleared by wb_en this cycle counts as not busy.
  - Illegal instruction: never stalls.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - Accept occurs when in_valid && in_ready.
  - The output register holds its contents while out_valid && !out_ready.
  - out_valid goes to 1 on accept; it clears when consumed with no new accept in the same cycle.
  - Back-to-back accept and consume in one cycle sustains 1 instruction/cycle.
- Latency: one cycle from accept to out_valid.
- Register read:
  - x0 always reads 0.
  - With ENABLE_BYPASS=1, if wb_en && wb_rd == read index && index != 0, the read returns wb_data.
- Output values:
  - out_rs2 is forced to 0 for OP-IMM.
  - out_funct7 is always instr[31:25], including shift-immediates, so SRAI yields 0x20.
- Illegal instruction:
  - out_illegal = 1, out_rd = 0, out_imm_select = 0, out_rs1 = out_rs2 = out_imm = 0.
  - No scoreboard set.
  - Still flows through the handshake.
- Scoreboard:
  - On accept of a legal instruction with rd != 0, set busy[rd].
  - On wb_en with wb_rd != 0, clear busy[wb_rd].
  - Same register set and cleared in one cycle: set wins, because the new instruction owns it.
- Writes:
  - wb_en with wb_rd = 0 is ignored (no write, no scoreboard change).
  - Writeback to a register whose busy bit is 0 still writes the data.
- No internal state machine beyond the out_valid flag. The busy vector bits are independent.
- Reset mid-operation: an asserted rst_n=0 drops the in-flight bundle, clears all busy bits, and zeroes the register file immediately.

Test Plan:
- Reset with rst_n=0, then release; send ADDI x1,x0,5 (0x00500093) -> next cycle: out_valid=1, out_imm=0x005, out_imm_select=1, out_funct3=0, out_rd=1, out_rs1=0, out_rs2=0; busy[1]=1.
- Then ADD x2,x1,x1 (0x00108133) with no writeback -> in_ready=0 for at least 3 cycles. Assert wb_en, wb_rd=1, wb_data=5 -> accepted in that same cycle (ENABLE_BYPASS=1), next cycle out_rs1=5, out_rs2=5, out_rd=2; busy[1]=0, busy[2]=1.
- SRAI x3,x1,4 (0x4040D193) with x1 = 0x80000000 written earlier -> out_imm=0x404, out_funct7=0x20, out_funct3=5, out_rs1=0x80000000.
- Backpressure: hold out_ready=0 across 4 cycles with in_valid=1 -> outputs stable and in_ready=0. Release -> pending instruction shifts in and out_valid stays 1 with no bubble.
- Illegal opcode 0x0000006F -> out_illegal=1, out_rd=0, busy vector unchanged. Writeback wb_rd=0, wb_data=0xFFFFFFFF -> a later read of x0 returns 0.
- Drive rst_n low while out_valid=1 and busy[5]=1 -> out_valid=0 and busy cleared without waiting for a clock edge. An instruction reading x5 after release -> out_rs1=0 with no stall.
